multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_core.sv | 99 +++++++++
 rtl/multicycle_alu.sv | 166 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op codes, FSM state encoding and op-class helper shared by
//               the multicycle ALU and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] c_op_pass_a = 5'h00;
    localparam logic [4:0] c_op_pass_b = 5'h01;
    localparam logic [4:0] c_op_and    = 5'h02;
    localparam logic [4:0] c_op_or     = 5'h03;
    localparam logic [4:0] c_op_xor    = 5'h04;
    localparam logic [4:0] c_op_add    = 5'h05;
    localparam logic [4:0] c_op_adc    = 5'h06;
    localparam logic [4:0] c_op_cmp    = 5'h07;
    localparam logic [4:0] c_op_sub    = 5'h08;
    localparam logic [4:0] c_op_sbb    = 5'h09;
    localparam logic [4:0] c_op_sll    = 5'h0A;
    localparam logic [4:0] c_op_srl    = 5'h0B;
    localparam logic [4:0] c_op_sra    = 5'h0C;
    localparam logic [4:0] c_op_rlc    = 5'h0D;
    localparam logic [4:0] c_op_rrc    = 5'h0E;
    localparam logic [4:0] c_op_not    = 5'h0F;
    localparam logic [4:0] c_op_mul    = 5'h10;
    localparam logic [4:0] c_op_divu   = 5'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_MULTI   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        if (op[4] == 1'b0) begin
            return CLS_SINGLE;
        end else if (op == c_op_mul || op == c_op_divu) begin
            return CLS_MULTI;
        end else begin
            return CLS_ILLEGAL;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational single-cycle ALU (ops 0x00-0x0F) with flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             zout,
    output logic             nout
);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_cin_ext;

    assign w_cin_ext = {{WIDTH{1'b0}}, cin};

    always_comb begin
        w_ext = '0;
        res   = a;
        cout  = cin;
        zout  = 1'b0;
        nout  = 1'b0;
        case (op)
            c_op_pass_a: res = a;
            c_op_pass_b: res = b;
            c_op_and:    res = a & b;
            c_op_or:     res = a | b;
            c_op_xor:    res = a ^ b;
            c_op_add: begin
                w_ext = {1'b0, a} + {1'b0, b};
                res   = w_ext[WIDTH-1:0];
                cout  = w_ext[WIDTH];
            end
            c_op_adc: begin
                w_ext = {1'b0, a} + {1'b0, b} + w_cin_ext;
                res   = w_ext[WIDTH-1:0];
                cout  = w_ext[WIDTH];
            end
            c_op_cmp:    res = a;
            // Bit WIDTH of the extended difference is the borrow
            c_op_sub: begin
                w_ext = {1'b0, a} - {1'b0, b};
                res   = w_ext[WIDTH-1:0];
                cout  = w_ext[WIDTH];
            end
            c_op_sbb: begin
                w_ext = {1'b0, a} - {1'b0, b} - w_cin_ext;
                res   = w_ext[WIDTH-1:0];
                cout  = w_ext[WIDTH];
            end
            c_op_sll: begin
                res  = {a[WIDTH-2:0], 1'b0};
                cout = a[WIDTH-1];
            end
            c_op_srl: begin
                res  = {1'b0, a[WIDTH-1:1]};
                cout = a[0];
            end
            c_op_sra: begin
                res  = {a[WIDTH-1], a[WIDTH-1:1]};
                cout = a[0];
            end
            c_op_rlc: begin
                res  = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            c_op_rrc: begin
                res  = {cin, a[WIDTH-1:1]};
                cout = a[0];
            end
            c_op_not:    res = ~a;
            default: begin
                res  = '0;
                cout = 1'b0;
            end
        endcase

        if (op == c_op_cmp) begin
            cout = (a > b);
            zout = (a == b);
            nout = (a < b);
        end else begin
            zout = (res == '0);
            nout = res[WIDTH-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Sequenced ALU: single-cycle ops via alu_core, shift-add MUL
//               and restoring DIVU at one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             cout,
    output logic             zout,
    output logic             nout,
    output logic             vout
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_core_res;
    logic             w_core_cout;
    logic             w_core_zout;
    logic             w_core_nout;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_trial;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op   (op),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .res  (w_core_res),
        .cout (w_core_cout),
        .zout (w_core_zout),
        .nout (w_core_nout)
    );

    // {r_acc, r_q} is the product / {remainder, quotient} register pair.
    // With b == 0 every trial succeeds, which naturally yields an all-ones
    // quotient and a remainder equal to the dividend.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_acc, r_q[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_trial = w_div_shift[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_acc_nxt = w_div_ge ? w_div_trial : w_div_shift[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_acc_nxt = w_mul_sum[WIDTH:1];
            w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_lo   <= '0;
            res_hi   <= '0;
            cout     <= 1'b0;
            zout     <= 1'b0;
            nout     <= 1'b0;
            vout     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op_class(op) == CLS_MULTI) begin
                            r_state  <= ST_RUN;
                            r_cnt    <= '0;
                            r_is_div <= (op == c_op_divu);
                            r_acc    <= '0;
                            r_q      <= a;
                            r_b      <= b;
                        end else begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            res_hi  <= '0;
                            if (op_class(op) == CLS_SINGLE) begin
                                res_lo <= w_core_res;
                                cout   <= w_core_cout;
                                zout   <= w_core_zout;
                                nout   <= w_core_nout;
                                vout   <= 1'b0;
                            end else begin
                                res_lo <= '0;
                                cout   <= 1'b0;
                                zout   <= 1'b1;
                                nout   <= 1'b0;
                                vout   <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        res_lo  <= w_q_nxt;
                        res_hi  <= w_acc_nxt;
                        if (r_is_div) begin
                            cout <= 1'b0;
                            zout <= (w_q_nxt == '0);
                            nout <= w_q_nxt[WIDTH-1];
                            vout <= (r_b == '0);
                        end else begin
                            cout <= (w_acc_nxt != '0);
                            zout <= ({w_acc_nxt, w_q_nxt} == '0);
                            nout <= w_acc_nxt[WIDTH-1];
                            vout <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Scoreboard bench for multicycle_alu (WIDTH=8 and WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        cout;
    logic        zout;
    logic        nout;
    logic        vout;

    logic        start16;
    logic [4:0]  op16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] res_lo16;
    logic [15:0] res_hi16;
    logic        cout16;
    logic        zout16;
    logic        nout16;
    logic        vout16;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    multicycle_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
        .cout(cout), .zout(zout), .nout(nout), .vout(vout)
    );

    multicycle_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .res_lo(res_lo16), .res_hi(res_hi16),
        .cout(cout16), .zout(zout16), .nout(nout16), .vout(vout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model8(input logic [4:0] o, input logic [7:0] x,
                                    input logic [7:0] y, input logic ci);
        exp_t       e;
        logic [8:0] s;
        logic [15:0] p;
        e.lo = 8'h00; e.hi = 8'h00; e.c = 1'b0; e.z = 1'b0; e.n = 1'b0; e.v = 1'b0;
        e.lat = 1;
        s = 9'h000;
        p = 16'h0000;
        case (o)
            5'h00: begin e.lo = x;      e.c = ci; end
            5'h01: begin e.lo = y;      e.c = ci; end
            5'h02: begin e.lo = x & y;  e.c = ci; end
            5'h03: begin e.lo = x | y;  e.c = ci; end
            5'h04: begin e.lo = x ^ y;  e.c = ci; end
            5'h05: begin s = 9'(x) + 9'(y);          e.lo = s[7:0]; e.c = s[8]; end
            5'h06: begin s = 9'(x) + 9'(y) + 9'(ci); e.lo = s[7:0]; e.c = s[8]; end
            5'h07: begin e.lo = x; e.c = (x > y); end
            5'h08: begin e.lo = x - y; e.c = (x < y); end
            5'h09: begin e.lo = x - y - 8'(ci); e.c = (9'(x) < 9'(y) + 9'(ci)); end
            5'h0A: begin e.lo = x << 1;           e.c = x[7]; end
            5'h0B: begin e.lo = x >> 1;           e.c = x[0]; end
            5'h0C: begin e.lo = {x[7], x[7:1]};   e.c = x[0]; end
            5'h0D: begin e.lo = {x[6:0], ci};     e.c = x[7]; end
            5'h0E: begin e.lo = {ci, x[7:1]};     e.c = x[0]; end
            5'h0F: begin e.lo = ~x;               e.c = ci;   end
            5'h10: begin
                p = 16'(x) * 16'(y);
                e.lo = p[7:0]; e.hi = p[15:8]; e.c = (p[15:8] != 8'h00); e.lat = 9;
            end
            5'h11: begin
                e.lat = 9;
                if (y == 8'h00) begin
                    e.lo = 8'hFF; e.hi = x; e.v = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: e.v = 1'b1;
        endcase
        if (o == 5'h07) begin
            e.z = (x == y);
            e.n = (x < y);
        end else if (o <= 5'h0F || o == 5'h11) begin
            e.z = (e.lo == 8'h00);
            e.n = e.lo[7];
        end else if (o == 5'h10) begin
            e.z = (p == 16'h0000);
            e.n = e.hi[7];
        end else begin
            e.z = 1'b1;
        end
        return e;
    endfunction

    // pulse_at > 0: stray start in that cycle of the run; -1: stray start in the done cycle
    task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input int pulse_at);
        exp_t e;
        int   lat;
        sb.push_back(model8(o, x, y, ci));
        op = o; a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 5'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            chk("busy_run", 32'(busy), 32'd1);
            if (lat == pulse_at) begin
                start = 1'b1;
                op    = c_op_add;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("res_lo", 32'(res_lo), 32'(e.lo));
        chk("res_hi", 32'(res_hi), 32'(e.hi));
        chk("cout", 32'(cout), 32'(e.c));
        chk("zout", 32'(zout), 32'(e.z));
        chk("nout", 32'(nout), 32'(e.n));
        chk("vout", 32'(vout), 32'(e.v));
        if (pulse_at == -1) begin
            start = 1'b1;
            op    = c_op_mul;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("hold_lo", 32'(res_lo), 32'(e.lo));
        chk("hold_hi", 32'(res_hi), 32'(e.hi));
    endtask

    initial begin
        int   lat;
        logic seen;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; start = 1'b0; op = 5'h00; a = 8'h00; b = 8'h00; cin = 1'b0;
        start16 = 1'b0; op16 = 5'h00; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", {res_hi, res_lo, 16'h0000}, 32'd0);
        chk("rst_flags", {28'd0, cout, zout, nout, vout}, 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        rst = 1'b0;

        run8(c_op_add,  8'hFF, 8'h01, 1'b0, 0);
        run8(c_op_cmp,  8'h10, 8'h20, 1'b0, 0);
        run8(c_op_mul,  8'hFF, 8'hFF, 1'b0, 3);
        run8(c_op_divu, 8'd200, 8'd7, 1'b0, 0);
        run8(c_op_divu, 8'h55, 8'h00, 1'b0, 0);
        run8(c_op_cmp,  8'h33, 8'h33, 1'b1, 0);
        run8(c_op_sbb,  8'h05, 8'h05, 1'b1, 0);
        run8(c_op_mul,  8'h00, 8'hA7, 1'b0, 0);
        run8(c_op_divu, 8'h05, 8'h09, 1'b0, 0);
        for (int i = 0; i < 32; i++) begin
            run8(5'(i), 8'($urandom), 8'($urandom), 1'($urandom),
                 (i == 16 || i == 17) ? 5 : -1);
        end
        for (int i = 0; i < 6; i++) begin
            run8((i % 2 == 0) ? c_op_mul : c_op_divu, 8'($urandom), 8'($urandom_range(1, 255)),
                 1'b0, 0);
        end

        // Abort a MUL in its fourth cycle
        run8(c_op_pass_a, 8'h5A, 8'h00, 1'b1, 0);
        op = c_op_mul; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res", {res_hi, res_lo, 16'h0000}, 32'd0);
        chk("abort_flags", {28'd0, cout, zout, nout, vout}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Reset wins over a simultaneous start
        op = c_op_add; a = 8'h01; b = 8'h02; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_start_drop", 32'(seen), 32'd0);
        run8(c_op_sub, 8'h10, 8'h20, 1'b0, 0);

        // WIDTH=16 multiply
        op16 = c_op_mul; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            chk("busy16_run", 32'(busy16), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency16", 32'(lat), 32'd17);
        chk("res_hi16", 32'(res_hi16), 32'h0001);
        chk("res_lo16", 32'(res_lo16), 32'hFFFE);
        chk("cout16", 32'(cout16), 32'd1);
        chk("zout16", 32'(zout16), 32'd0);
        @(posedge clk); #1;
        chk("busy16_idle", 32'(busy16), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
